uart_tx_feeder: RTL
===================

Name: uart_tx_feeder

Overview:
- Write-side buffer and handshake sequencer directly upstream of the UART2 transmit port.
- Accepts 16-bit words from a producer (CPU bridge / debug logger) into a synchronous FIFO.
- Presents each word to UART2 as a single-cycle TX_DATA_VAL pulse, only while TX_BUSY is low.
- Guards against TX_BUSY rising one or more cycles after the pulse, and against CTS-driven busy.

Parameters:
DATA_W, 16, word width; matches UART2 TX_DATA.
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16.
HOLDOFF, 4, cycles to wait for TX_BUSY to rise after a pulse before treating the word as taken; range 1..15.

Ports:
CLK  in  1  system clock, single domain
RST  in  1  synchronous reset, active-high
WR_DATA  in  DATA_W  producer word
WR_EN  in  1  push WR_DATA this cycle
FLUSH  in  1  discard all buffered words and clear OVERFLOW
FULL  out  1  FIFO holds 2**ADDR_W words
EMPTY  out  1  FIFO holds 0 words
LEVEL  out  ADDR_W+1  current word count, 0..2**ADDR_W
OVERFLOW  out  1  sticky: a push arrived while FULL
TX_DATA  out  DATA_W  word to UART2 TX_DATA
TX_DATA_VAL  out  1  one-cycle send strobe to UART2 TX_DATA_VAL
TX_BUSY  in  1  from UART2 TX_BUSY (transmitter busy OR CTS high)

Behaviour:
- Reset (RST=1 sampled at posedge): pointers=0, LEVEL=0, EMPTY=1, FULL=0, OVERFLOW=0, TX_DATA=0, TX_DATA_VAL=0, FSM=IDLE. Memory contents are not reset.
- FIFO storage: 2**ADDR_W x DATA_W.
  - Read/write pointers are ADDR_W+1 bits; the extra MSB disambiguates full from empty.
  - Pointers wrap naturally modulo 2**(ADDR_W+1).
  - LEVEL = wr_ptr - rd_ptr, registered. FULL and EMPTY are decoded from the registered pointers.
- Push: WR_EN=1 and FULL=0 stores WR_DATA at wr_ptr and increments wr_ptr at that edge.
- Overflow: WR_EN=1 with FULL=1 drops the word and sets OVERFLOW=1. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): both take effect and LEVEL is unchanged.
- FLUSH=1:
  - Sets rd_ptr=wr_ptr=0 and clears OVERFLOW.
  - A WR_EN in the same cycle is dropped; FLUSH wins.
  - FSM state, TX_DATA and TX_DATA_VAL are untouched, so an in-flight word finishes its handshake.
- FSM states:
  - IDLE: if EMPTY=0 and TX_BUSY=0 at the edge, then TX_DATA <= mem[rd_ptr], TX_DATA_VAL <= 1, rd_ptr++, holdoff counter <= 0, go to ARM. Otherwise TX_DATA_VAL <= 0.
  - ARM: TX_DATA_VAL <= 0.
    - If TX_BUSY=1, go to DRAIN.
    - Else if counter = HOLDOFF-1, go to IDLE (word considered taken).
    - Else counter++.
  - DRAIN: TX_DATA_VAL=0. When TX_BUSY is sampled 0, go to IDLE.
- Timing and latency:
  - TX_DATA_VAL is high for exactly one cycle per word. TX_DATA holds the word until the next launch.
  - Word pushed at edge k into an empty FIFO, with TX_BUSY=0: TX_DATA_VAL is high in the cycle after edge k+1 (latency 2).
  - Minimum spacing between pulses is HOLDOFF+1 cycles when TX_BUSY never rises. Otherwise spacing is busy duration + 2.
- Ordering: words leave in strict push order. No word is launched twice, and none is skipped except through FLUSH or overflow.
- TX_BUSY held high indefinitely (CTS deasserted): the FSM stays in IDLE or DRAIN and the FIFO fills to FULL with no loss except overflow.
- Reset mid-transfer: everything returns to reset values immediately. UART2 may still be sending the last word; that is not aborted.

Test Plan:
- Reset, push 0x0041 with TX_BUSY=0, model busy rising 1 cycle after the strobe for 10 cycles -> one TX_DATA_VAL pulse with TX_DATA=0x0041 two cycles after push; LEVEL returns to 0; no second pulse.
- Push 16 words 0x0000..0x000F back-to-back, then a 17th (0x00FF) -> FULL=1 after the 16th; OVERFLOW=1; 0x00FF never appears; 16 pulses emerge in order.
- TX_BUSY stuck high for 200 cycles, push 3 words, then release -> no pulse while busy; after release, 3 pulses in order, each after busy has dropped.
- Busy model never rises, HOLDOFF=4, push 2 words -> pulses exactly 5 cycles apart.
- With 5 words queued and a word in flight (state DRAIN), assert FLUSH together with WR_EN=0x1234 -> LEVEL=0, OVERFLOW=0, 0x1234 dropped; the in-flight word completes and no further pulses occur.
- Assert RST during DRAIN with LEVEL=7 -> next cycle LEVEL=0, EMPTY=1, TX_DATA_VAL=0, TX_DATA=0, FSM=IDLE.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: word FIFO plus launch sequencer feeding the UART2 transmit port.
// Each buffered word is presented as a one-cycle strobe while the transmitter is idle.
// After launching, the sequencer waits for TX_BUSY to rise before releasing the next word.
module uart_tx_feeder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int HOLDOFF = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_EN,
  input  logic              FLUSH,
  output logic              FULL,
  output logic              EMPTY,
  output logic [ADDR_W:0]   LEVEL,
  output logic              OVERFLOW,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_DATA_VAL,
  input  logic              TX_BUSY
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      HOLD_LAST = 4'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DRAIN
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_val_q, tx_val_d;
  logic [3:0]        cnt_q, cnt_d;
  state_t            state_q, state_d;

  logic full, empty, push, launch;

  // Full when the pointers differ only in the wrap bit; empty when identical.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign push   = WR_EN && !full && !FLUSH;
  // A flush discards the head word, so no launch is started in that cycle.
  assign launch = (state_q == IDLE) && !empty && !TX_BUSY && !FLUSH;

  // Pointer, level and sticky overflow updates; flush overrides push and pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (FLUSH) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (launch) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (WR_EN && full) begin
        overflow_d = 1'b1;
      end
    end
    level_d = wr_ptr_d - rd_ptr_d;
  end

  // Launch sequencer: strobe a word, then watch for TX_BUSY or give up after the holdoff.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_val_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          tx_data_d = mem[rd_ptr_q[ADDR_W-1:0]];
          tx_val_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (TX_BUSY) begin
          state_d = DRAIN;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DRAIN: begin
        if (!TX_BUSY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word storage; contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= WR_DATA;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      tx_val_q   <= 1'b0;
      cnt_q      <= '0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_val_q   <= tx_val_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  assign FULL        = full;
  assign EMPTY       = empty;
  assign LEVEL       = level_q;
  assign OVERFLOW    = overflow_q;
  assign TX_DATA     = tx_data_q;
  assign TX_DATA_VAL = tx_val_q;

endmodule
